// File: rtl/uart_pkg.sv
// Shared UART datapath definitions: byte/word geometry and the TX sequencer state encoding.
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_WORD_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_wdog.sv
// WAIT watchdog: down-counter loaded on entry to WAIT, expires at terminal count while running.
module uart_tx_wdog #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = ($clog2(CYCLES) > 0) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_tx_seq.sv
// Word-to-byte sequencer for the 8-bit UART transmitter; WAIT watchdog and timeout_err
// are enabled by UART_TX_SEQ_TIMEOUT_EN (otherwise WAIT blocks and timeout_err stays 0).
//
// state | meaning
// IDLE  | ready for a word
// SEND  | present next byte, pulse tx_en
// WAIT  | wait for rising edge of tx_done
// GAP   | idle gap before the next byte
module uart_tx_seq
  import uart_pkg::*;
#(
  parameter int NBYTES         = UART_WORD_BYTES,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [UART_BYTE_W*NBYTES-1:0] s_data,
  output logic [UART_BYTE_W-1:0]        tx_data,
  output logic                          tx_en,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(NBYTES)-1:0]     byte_idx,
  output logic                          word_done,
  output logic                          timeout_err
);

  localparam int IW = $clog2(NBYTES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  tx_state_t                     state, state_nxt;
  logic [UART_BYTE_W*NBYTES-1:0] shreg, shreg_nxt;
  logic [GW-1:0]                 gap_cnt, gap_nxt;
  logic                          tx_done_q;
  logic                          done_rise;
  logic                          wd_expired;
  logic                          s_ready_nxt, tx_en_nxt, busy_nxt, word_done_nxt, timeout_nxt;
  logic [UART_BYTE_W-1:0]        tx_data_nxt;
  logic [IW-1:0]                 idx_nxt;

  // A level left high by the previous byte must not count as completion.
  assign done_rise = tx_done & ~tx_done_q;

`ifdef UART_TX_SEQ_TIMEOUT_EN
  uart_tx_wdog #(.CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state == ST_SEND),
    .run     (state == ST_WAIT),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    gap_nxt       = gap_cnt;
    s_ready_nxt   = 1'b0;
    tx_en_nxt     = 1'b0;
    tx_data_nxt   = tx_data;
    busy_nxt      = busy;
    idx_nxt       = byte_idx;
    word_done_nxt = 1'b0;
    timeout_nxt   = timeout_err;
    case (state)
      ST_IDLE: begin
        s_ready_nxt = 1'b1;
        if (s_valid && s_ready) begin
          shreg_nxt   = s_data;
          idx_nxt     = '0;
          s_ready_nxt = 1'b0;
          busy_nxt    = 1'b1;
          timeout_nxt = 1'b0;
          state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_nxt = shreg[UART_BYTE_W-1:0];
        shreg_nxt   = shreg >> UART_BYTE_W;
        tx_en_nxt   = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          if (byte_idx == LAST_IDX) begin
            word_done_nxt = 1'b1;
            busy_nxt      = 1'b0;
            s_ready_nxt   = 1'b1;
            state_nxt     = ST_IDLE;
          end else begin
            idx_nxt = byte_idx + 1'b1;
            if (GAP_CYCLES == 0) begin
              state_nxt = ST_SEND;
            end else begin
              gap_nxt   = GAP_LOAD;
              state_nxt = ST_GAP;
            end
          end
        end else if (wd_expired) begin
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
          s_ready_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_SEND;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      gap_cnt     <= '0;
      tx_done_q   <= 1'b0;
      s_ready     <= 1'b0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      byte_idx    <= '0;
      word_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      gap_cnt     <= gap_nxt;
      tx_done_q   <= tx_done;
      s_ready     <= s_ready_nxt;
      tx_en       <= tx_en_nxt;
      tx_data     <= tx_data_nxt;
      busy        <= busy_nxt;
      byte_idx    <= idx_nxt;
      word_done   <= word_done_nxt;
      timeout_err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Scoreboard bench for uart_tx_seq: byte order, pulse widths, gap latency, held tx_done,
// back-to-back words, mid-word reset and (with UART_TX_SEQ_TIMEOUT_EN) the WAIT timeout.
module tb_uart_tx_seq;

  localparam int NB  = 16;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready;
  logic [127:0]  s_data;
  logic [7:0]    tx_data;
  logic          tx_en, tx_done, busy, word_done, timeout_err;
  logic [3:0]    byte_idx;

  logic          v0, r0, txe0, done0, busy0, wd0, to0;
  logic [15:0]   d0;
  logic [7:0]    txd0;
  logic [0:0]    idx0;

  always #5 clk = ~clk;

  uart_tx_seq #(.NBYTES(NB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done), .busy(busy),
    .byte_idx(byte_idx), .word_done(word_done), .timeout_err(timeout_err)
  );

  uart_tx_seq #(.NBYTES(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .s_valid(v0), .s_ready(r0), .s_data(d0),
    .tx_data(txd0), .tx_en(txe0), .tx_done(done0), .busy(busy0),
    .byte_idx(idx0), .word_done(wd0), .timeout_err(to0)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int wd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         idx;
  } exp_t;

  exp_t byte_q[$];
  int   word_q[$];

  task automatic push_word(input logic [127:0] w);
    for (int i = 0; i < NB; i++) byte_q.push_back('{w[8*i +: 8], i});
    word_q.push_back(1);
  endtask

  // Transmitter model: drops done on tx_en (unless holding), raises it dly cycles later.
  int dly      = 12;
  int hold_cyc = 0;
  bit stuck    = 0;
  bit have_done = 0;
  int done_cyc  = 0;

  initial begin
    int cnt;
    int hcnt;
    bit pend;
    cnt = 0; hcnt = 0; pend = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        tx_done = 1'b0;
      end else if (tx_en) begin
        if (hold_cyc == 0) tx_done = 1'b0;
        hcnt = hold_cyc;
        cnt  = dly;
        pend = 1;
      end else if (pend) begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) tx_done = 1'b0;
        end else if (!stuck) begin
          if (cnt > 0) cnt--;
          if (cnt == 0) begin
            tx_done   = 1'b1;
            pend      = 0;
            have_done = 1;
            done_cyc  = cyc;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every tx_en and word_done.
  initial begin
    bit en_prev;
    bit wd_prev;
    exp_t e;
    en_prev = 0; wd_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_prev = 0; wd_prev = 0; have_done = 0;
        continue;
      end
      if (tx_en) begin
        chk("tx_en_width", en_prev, 0);
        chk("tx_unexpected", byte_q.size() != 0, 1);
        if (byte_q.size() != 0) begin
          e = byte_q.pop_front();
          chk("tx_data", tx_data, e.b);
          chk("byte_idx", byte_idx, e.idx);
        end
        if (have_done) begin
          chk("gap_latency", cyc - done_cyc, GAP + 2);
          have_done = 0;
        end
      end
      if (word_done) begin
        chk("word_done_width", wd_prev, 0);
        chk("word_done_unexpected", word_q.size() != 0, 1);
        chk("word_done_bytes_left", byte_q.size(), 0);
        chk("word_done_busy", busy, 0);
        if (word_q.size() != 0) void'(word_q.pop_front());
        have_done = 0;
        wd_cnt++;
      end
      en_prev = tx_en;
      wd_prev = word_done;
    end
  end

  task automatic send_word(input logic [127:0] w, input bit keep);
    bit ok;
    ok = 0;
    push_word(w);
    s_data  = w;
    s_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (s_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("accept_wait", ok, 1);
    @(posedge clk);
    #1;
    if (!keep) s_valid = 1'b0;
    @(negedge clk);
    chk("accept_state", {busy, s_ready, tx_en}, 3'b100);
  endtask

  task automatic wait_word(input int budget);
    int start;
    start = wd_cnt;
    for (int i = 0; i < budget; i++) begin
      if (wd_cnt != start) break;
      @(negedge clk);
      #1;
    end
    chk("word_done_wait", wd_cnt != start, 1);
  endtask

  task automatic wait_tx_en(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_en) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  task automatic run_gap0();
    bit ok;
    int c;
    logic [7:0] exp_b;
    c = 0;
    d0 = 16'hB2A1;
    v0 = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (r0) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("g0_accept", ok, 1);
    @(posedge clk);
    #1 v0 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (txe0) begin ok = 1; break; end
      end
      chk("g0_tx_en_wait", ok, 1);
      exp_b = d0[8*b +: 8];
      chk("g0_tx_data", txd0, exp_b);
      if (b == 1) chk("g0_latency", cyc - c, 2);
      done0 = 1'b0;
      repeat (3) @(negedge clk);
      done0 = 1'b1;
      c = cyc;
    end
    @(negedge clk);
    chk("g0_word_done", {wd0, busy0}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [127:0] w;
    int saved_wd;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    v0 = 1'b0; d0 = '0; done0 = 1'b0;

    repeat (5) @(negedge clk);
    chk("reset_outputs", {s_ready, tx_en, tx_data, busy, byte_idx, word_done, timeout_err}, 0);
    chk("reset_outputs_g0", {r0, txe0, txd0, busy0, idx0, wd0, to0}, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", s_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", s_ready, 1);

    run_gap0();

    // Counting word: byte i carries value i; first tx_en one cycle after accept.
    for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'(i);
    send_word(w, 0);
    @(negedge clk);
    chk("accept_to_tx_en", tx_en, 1);
    wait_word(600);
    chk("idle_after_word", {busy, s_ready}, 2'b01);

    // Random data, short transmitter latency.
    dly = 3;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    wait_word(400);

    // Next word presented while busy must wait for IDLE.
    dly = 5;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 1);
    w = ~w ^ {4{32'h5A5A_A5A5}};
    s_data = w;
    wait_word(400);
    chk("ready_with_word_done", s_ready, 1);
    push_word(w);
    @(negedge clk);
    chk("second_word_accept", {busy, s_ready}, 2'b10);
    s_valid = 1'b0;
    wait_word(400);

    // tx_done left high across SEND/WAIT entry.
    hold_cyc = 6;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    wait_tx_en("hold_tx_en_wait");
    repeat (4) @(negedge clk);
    chk("hold_no_advance", {byte_idx, tx_en}, 5'b00000);
    wait_word(800);
    hold_cyc = 0;

    // Reset in the middle of a word.
    dly = 4;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    for (int i = 0; i < 200 && byte_q.size() > 12; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midword_reset", {s_ready, tx_en, tx_data, busy, byte_idx, word_done, timeout_err}, 0);
    byte_q.delete();
    word_q.delete();
    saved_wd = wd_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_word_done_after_reset", wd_cnt, saved_wd);
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    wait_word(400);

`ifdef UART_TX_SEQ_TIMEOUT_EN
    stuck = 1;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    wait_tx_en("timeout_tx_en_wait");
    saved_wd = wd_cnt;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) chk("timeout_early", timeout_err, 0);
    end
    chk("timeout_at_64", {timeout_err, busy}, 2'b10);
    byte_q.delete();
    word_q.delete();
    stuck = 0;
    repeat (20) @(negedge clk);
    chk("timeout_no_word_done", wd_cnt, saved_wd);
    chk("done_outside_wait_ignored", {busy, tx_en, timeout_err}, 3'b001);
    have_done = 0;
    w = {$urandom, $urandom, $urandom, $urandom};
    send_word(w, 0);
    chk("timeout_cleared_on_accept", timeout_err, 0);
    wait_word(400);
`else
    chk("timeout_tied_low", timeout_err, 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", byte_q.size() + word_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
